// File: rtl/digital_clock_pkg.sv
// Shared types, limits and BCD helper for the time-of-day counter.
// Imported by the interface, the counter and the top.
package digital_clock_pkg;

    typedef logic [7:0] bcd2_t;

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } clk_state_t;

    localparam bcd2_t SEC_MAX  = 8'h59;
    localparam bcd2_t MIN_MAX  = 8'h59;
    localparam bcd2_t HR24_MAX = 8'h23;
    localparam bcd2_t HR12_MAX = 8'h12;
    localparam bcd2_t HR12_MIN = 8'h01;

    function automatic bcd2_t bcd_inc(input bcd2_t v);
        bcd2_t r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/digital_clock_if.sv
// Control inputs and BCD time outputs of the clock core.
// Alarm signals exist only when DIGITAL_CLOCK_ALARM_EN is defined.
interface digital_clock_if;
    import digital_clock_pkg::*;

    logic  ONE_HZ_PULSE;
    logic  Set_Mode;
    logic  Inc_Min;
    logic  Inc_Hour;
    bcd2_t SEC_BCD;
    bcd2_t MIN_BCD;
    bcd2_t HOUR_BCD;
    logic  PM;
    logic  TIME_STROBE;

`ifdef DIGITAL_CLOCK_ALARM_EN
    bcd2_t ALARM_HOUR;
    bcd2_t ALARM_MIN;
    logic  ALARM_PM;
    logic  Alarm_En;
    logic  Alarm_Ack;
    logic  ALARM_OUT;

    modport master (
        output ONE_HZ_PULSE, Set_Mode, Inc_Min, Inc_Hour,
        output ALARM_HOUR, ALARM_MIN, ALARM_PM,
        output Alarm_En, Alarm_Ack,
        input  SEC_BCD, MIN_BCD, HOUR_BCD, PM, TIME_STROBE,
        input  ALARM_OUT
    );

    modport slave (
        input  ONE_HZ_PULSE, Set_Mode, Inc_Min, Inc_Hour,
        input  ALARM_HOUR, ALARM_MIN, ALARM_PM,
        input  Alarm_En, Alarm_Ack,
        output SEC_BCD, MIN_BCD, HOUR_BCD, PM, TIME_STROBE,
        output ALARM_OUT
    );
`else
    modport master (
        output ONE_HZ_PULSE, Set_Mode, Inc_Min, Inc_Hour,
        input  SEC_BCD, MIN_BCD, HOUR_BCD, PM, TIME_STROBE
    );

    modport slave (
        input  ONE_HZ_PULSE, Set_Mode, Inc_Min, Inc_Hour,
        output SEC_BCD, MIN_BCD, HOUR_BCD, PM, TIME_STROBE
    );
`endif

endinterface

// File: rtl/digital_clock_bcd_mod_counter.sv
// Two-digit BCD modulo counter wrapping MAX -> MIN.
// load_min overrides inc; carry flags an increment taken at MAX.
module bcd_mod_counter
    import digital_clock_pkg::*;
#(
    parameter bcd2_t MAX = SEC_MAX,
    parameter bcd2_t MIN = 8'h00,
    parameter bcd2_t RST = MIN
) (
    input  logic  clk_i,
    input  logic  rst_n_i,
    input  logic  inc_i,
    input  logic  load_min_i,
    output bcd2_t value_o,
    output logic  carry_o
);

    bcd2_t value_q;
    bcd2_t value_d;

    always_comb begin
        value_d = value_q;
        if (load_min_i) begin
            value_d = MIN;
        end else if (inc_i) begin
            value_d = (value_q == MAX) ? MIN : bcd_inc(value_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            value_q <= RST;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign carry_o = inc_i & (value_q == MAX);

endmodule

// File: rtl/digital_clock_core.sv
// HH:MM:SS BCD time-of-day counter advanced by rising edges of a 1 Hz input.
// Optional alarm compare/latch enabled by defining DIGITAL_CLOCK_ALARM_EN.
module digital_clock_core
    import digital_clock_pkg::*;
#(
    parameter bit HOUR_24 = 1'b1
) (
    input  logic            CLK_MHZ_50,
    input  logic            Clear,
    digital_clock_if.slave  bus
);

    localparam bcd2_t HR_MAX = HOUR_24 ? HR24_MAX : HR12_MAX;
    localparam bcd2_t HR_MIN = HOUR_24 ? 8'h00 : HR12_MIN;
    localparam bcd2_t HR_RST = HOUR_24 ? 8'h00 : HR12_MAX;

    clk_state_t state_q;
    clk_state_t state_d;
    logic       tick_q;
    logic       tick;
    logic       strobe_q;
    logic       strobe_d;
    logic       in_set;

    bcd2_t sec;
    bcd2_t min;
    bcd2_t hour;
    logic  sec_inc;
    logic  min_inc;
    logic  hr_inc;
    logic  sec_carry;
    logic  min_carry;
    logic  hr_carry;
    logic  pm;

    assign tick = bus.ONE_HZ_PULSE & ~tick_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (bus.Set_Mode)  state_d = SET;
            SET:     if (!bus.Set_Mode) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Act on the state being entered so SET wins over a same-cycle tick.
    assign in_set  = (state_d == SET);
    assign sec_inc = tick & ~in_set;
    assign min_inc = sec_carry | (in_set & bus.Inc_Min);
    assign hr_inc  = (min_carry & ~in_set) | (in_set & bus.Inc_Hour);

    assign strobe_d = sec_inc | min_inc | hr_inc | hr_carry
                    | (in_set & (sec != 8'h00));

    always_ff @(posedge CLK_MHZ_50) begin
        if (!Clear) begin
            state_q  <= RUN;
            tick_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= bus.ONE_HZ_PULSE;
            strobe_q <= strobe_d;
        end
    end

    bcd_mod_counter #(.MAX(SEC_MAX), .MIN(8'h00)) u_sec (
        .clk_i      (CLK_MHZ_50),
        .rst_n_i    (Clear),
        .inc_i      (sec_inc),
        .load_min_i (in_set),
        .value_o    (sec),
        .carry_o    (sec_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX), .MIN(8'h00)) u_min (
        .clk_i      (CLK_MHZ_50),
        .rst_n_i    (Clear),
        .inc_i      (min_inc),
        .load_min_i (1'b0),
        .value_o    (min),
        .carry_o    (min_carry)
    );

    bcd_mod_counter #(.MAX(HR_MAX), .MIN(HR_MIN), .RST(HR_RST)) u_hr (
        .clk_i      (CLK_MHZ_50),
        .rst_n_i    (Clear),
        .inc_i      (hr_inc),
        .load_min_i (1'b0),
        .value_o    (hour),
        .carry_o    (hr_carry)
    );

    generate
        if (HOUR_24) begin : g_no_pm
            assign pm = 1'b0;
        end else begin : g_pm
            logic pm_q;
            logic pm_d;

            // Meridiem flips on 11 -> 12, not on the 12 -> 01 wrap.
            always_comb begin
                pm_d = pm_q;
                if (hr_inc && (hour == 8'h11)) begin
                    pm_d = ~pm_q;
                end
            end

            always_ff @(posedge CLK_MHZ_50) begin
                if (!Clear) begin
                    pm_q <= 1'b0;
                end else begin
                    pm_q <= pm_d;
                end
            end

            assign pm = pm_q;
        end
    endgenerate

`ifdef DIGITAL_CLOCK_ALARM_EN
    logic alarm_q;
    logic alarm_d;
    logic alarm_hit;

    // strobe_q marks the first cycle showing a freshly changed time.
    assign alarm_hit = strobe_q
                     & (state_q == RUN)
                     & (hour == bus.ALARM_HOUR)
                     & (min == bus.ALARM_MIN)
                     & (sec == 8'h00)
                     & (HOUR_24 | (pm == bus.ALARM_PM));

    always_comb begin
        alarm_d = alarm_q;
        if (bus.Alarm_Ack || !bus.Alarm_En) begin
            alarm_d = 1'b0;
        end else if (alarm_hit) begin
            alarm_d = 1'b1;
        end
    end

    always_ff @(posedge CLK_MHZ_50) begin
        if (!Clear) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign bus.ALARM_OUT = alarm_q;
`endif

    assign bus.SEC_BCD     = sec;
    assign bus.MIN_BCD     = min;
    assign bus.HOUR_BCD    = hour;
    assign bus.PM          = pm;
    assign bus.TIME_STROBE = strobe_q;

endmodule

// File: tb/tb_digital_clock_core.sv
// Directed bench driving a 24 h and a 12 h instance with shared stimulus.
// Expected times are hand-computed constants per step.
module tb_digital_clock_core;
    import digital_clock_pkg::*;

    logic clk = 1'b0;
    logic clear = 1'b0;
    logic pulse = 1'b0;
    logic set_mode = 1'b0;
    logic inc_min = 1'b0;
    logic inc_hour = 1'b0;

    int n_assert = 0;
    int n_fail = 0;
    int s24 = 0;
    int s12 = 0;
    int b24;
    int b12;

    always #10 clk = ~clk;

    digital_clock_if if24();
    digital_clock_if if12();

    assign if24.ONE_HZ_PULSE = pulse;
    assign if24.Set_Mode     = set_mode;
    assign if24.Inc_Min      = inc_min;
    assign if24.Inc_Hour     = inc_hour;
    assign if12.ONE_HZ_PULSE = pulse;
    assign if12.Set_Mode     = set_mode;
    assign if12.Inc_Min      = inc_min;
    assign if12.Inc_Hour     = inc_hour;

`ifdef DIGITAL_CLOCK_ALARM_EN
    logic al_en = 1'b0;
    logic al_ack = 1'b0;

    assign if24.ALARM_HOUR = 8'h07;
    assign if24.ALARM_MIN  = 8'h30;
    assign if24.ALARM_PM   = 1'b0;
    assign if24.Alarm_En   = al_en;
    assign if24.Alarm_Ack  = al_ack;
    assign if12.ALARM_HOUR = 8'h07;
    assign if12.ALARM_MIN  = 8'h30;
    assign if12.ALARM_PM   = 1'b0;
    assign if12.Alarm_En   = al_en;
    assign if12.Alarm_Ack  = al_ack;
`endif

    digital_clock_core #(.HOUR_24(1'b1)) dut24 (
        .CLK_MHZ_50 (clk),
        .Clear      (clear),
        .bus        (if24)
    );

    digital_clock_core #(.HOUR_24(1'b0)) dut12 (
        .CLK_MHZ_50 (clk),
        .Clear      (clear),
        .bus        (if12)
    );

    logic [23:0] t24;
    logic [23:0] t12;
    assign t24 = {if24.HOUR_BCD, if24.MIN_BCD, if24.SEC_BCD};
    assign t12 = {if12.HOUR_BCD, if12.MIN_BCD, if12.SEC_BCD};

    always @(negedge clk) begin
        if (if24.TIME_STROBE === 1'b1) s24++;
        if (if12.TIME_STROBE === 1'b1) s12++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            pulse = 1'b1;
            step();
            pulse = 1'b0;
            step();
        end
    endtask

    task automatic incm(input int n);
        repeat (n) begin
            inc_min = 1'b1;
            step();
            inc_min = 1'b0;
        end
    endtask

    task automatic inch(input int n);
        repeat (n) begin
            inc_hour = 1'b1;
            step();
            inc_hour = 1'b0;
        end
    endtask

    task automatic enter_set();
        set_mode = 1'b1;
        step();
    endtask

    task automatic leave_set();
        set_mode = 1'b0;
        step();
    endtask

    task automatic do_reset();
        clear = 1'b0;
        step();
        clear = 1'b1;
        step();
    endtask

    initial begin
        clear = 1'b0;
        step();
        step();
        check("rst_t24", t24, 24'h000000);
        check("rst_strobe24", if24.TIME_STROBE, 1'b0);
        check("rst_pm24", if24.PM, 1'b0);
        check("rst_t12", t12, 24'h120000);
        check("rst_pm12", if12.PM, 1'b0);
        clear = 1'b1;
        step();

        enter_set();
        inch(11);
        incm(59);
        leave_set();
        check("load_t24", t24, 24'h115900);
        check("load_t12", t12, 24'h115900);
        ticks(59);
        check("run_t24", t24, 24'h115959);
        check("run_t12", t12, 24'h115959);
        check("am_pm12", if12.PM, 1'b0);
        b24 = s24;
        ticks(1);
        check("noon_t24", t24, 24'h120000);
        check("noon_t12", t12, 24'h120000);
        check("noon_pm12", if12.PM, 1'b1);
        check("noon_strb", s24 - b24, 1);

        enter_set();
        incm(59);
        leave_set();
        ticks(59);
        check("12xx_t12", t12, 24'h125959);
        ticks(1);
        check("one_t24", t24, 24'h130000);
        check("one_t12", t12, 24'h010000);
        check("one_pm12", if12.PM, 1'b1);

        enter_set();
        inch(10);
        incm(59);
        leave_set();
        ticks(58);
        check("pre_t24", t24, 24'h235958);
        check("pre_t12", t12, 24'h115958);
        b24 = s24;
        b12 = s12;
        ticks(1);
        check("d59_t24", t24, 24'h235959);
        ticks(1);
        check("wrap_t24", t24, 24'h000000);
        check("wrap_t12", t12, 24'h120000);
        check("wrap_pm12", if12.PM, 1'b0);
        check("wrap_s24", s24 - b24, 2);
        check("wrap_s12", s12 - b12, 2);

        do_reset();
        enter_set();
        inch(10);
        incm(20);
        leave_set();
        ticks(36);
        check("b_t24", t24, 24'h102036);
        b24 = s24;
        pulse = 1'b1;
        repeat (10) step();
        pulse = 1'b0;
        step();
        check("hold_t24", t24, 24'h102037);
        check("hold_t12", t12, 24'h102037);
        check("hold_strb", s24 - b24, 1);
        repeat (5) step();
        check("idle_t24", t24, 24'h102037);

        enter_set();
        check("set_sec0", t24, 24'h102000);
        ticks(3);
        check("set_noadv", t24, 24'h102000);
        incm(40);
        check("set_m40", t24, 24'h100000);
        inc_min = 1'b1;
        inc_hour = 1'b1;
        step();
        inc_min = 1'b0;
        inc_hour = 1'b0;
        check("set_both24", t24, 24'h110100);
        check("set_both12", t12, 24'h110100);
        check("set_pm12", if12.PM, 1'b0);
        leave_set();
        ticks(1);
        check("resume_t24", t24, 24'h110101);

        do_reset();
        enter_set();
        inch(5);
        incm(43);
        leave_set();
        ticks(21);
        check("c_t24", t24, 24'h054321);
        pulse = 1'b1;
        clear = 1'b0;
        step();
        pulse = 1'b0;
        clear = 1'b1;
        check("clr_t24", t24, 24'h000000);
        check("clr_t12", t12, 24'h120000);
        check("clr_strb", if24.TIME_STROBE, 1'b0);
        step();
        check("clr_hold", t24, 24'h000000);

`ifdef DIGITAL_CLOCK_ALARM_EN
        al_en = 1'b1;
        enter_set();
        inch(7);
        incm(29);
        leave_set();
        ticks(59);
        check("al_pre24", if24.ALARM_OUT, 1'b0);
        ticks(1);
        check("al_time", t24, 24'h073000);
        check("al_hit24", if24.ALARM_OUT, 1'b1);
        check("al_hit12", if12.ALARM_OUT, 1'b1);
        al_ack = 1'b1;
        step();
        al_ack = 1'b0;
        check("al_ack24", if24.ALARM_OUT, 1'b0);
        check("al_ack12", if12.ALARM_OUT, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
